lm_sm_sequencer: RTL and testbench
==================================

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and reset.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-003 Port reset SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and requests an LM/SM sequence.
REQ-005 Port is_load SHALL be an input, 1 bit wide: 1 selects LM, 0 selects SM.
REQ-006 Port mask SHALL be an input, 8 bits wide, and is the imm8 register mask; bit i selects Ri.
REQ-007 Port base_addr SHALL be an input, 16 bits wide, and is the base memory address (RA contents).
REQ-008 Port ready SHALL be an input, 1 bit wide, and signals that the downstream memory stage accepts the current transfer.
REQ-009 Port reg_addr SHALL be an output, 3 bits wide: the register-bank read address for SM, the write address for LM.
REQ-010 Port mem_addr SHALL be an output, 16 bits wide, and is the memory address of the current transfer.
REQ-011 Port valid SHALL be an output, 1 bit wide, and marks that reg_addr and mem_addr hold a live transfer.
REQ-012 Port load_o SHALL be an output, 1 bit wide, and is the captured is_load.
REQ-013 Port reg_we SHALL be an output, 1 bit wide, and is valid AND ready AND load_o (drives the bank writeEnable).
REQ-014 Port busy SHALL be an output, 1 bit wide; it is the upstream stall, asserted in any non-IDLE state.
REQ-015 Port done SHALL be an output, 1 bit wide, and is a single-cycle completion pulse.
REQ-016 Port xfer_count SHALL be an output, 4 bits wide, and counts transfers completed in the current sequence (0..8).

Function
REQ-017 The block SHALL implement the states IDLE, RUN and DONE.
REQ-018 In IDLE, a clock edge with start=1 SHALL capture mask, is_load and base_addr, clear xfer_count, and move to RUN; if the effective mask is zero, it SHALL move to DONE instead.
REQ-019 In RUN, valid SHALL be 1 and reg_addr SHALL equal the index of the lowest set bit of the remaining mask (ascending order R0..R7).
REQ-020 A transfer SHALL complete only on an edge with valid=1 and ready=1; on that edge the block SHALL clear the bit, increment mem_addr by 1 (16-bit wrap, FFFF to 0000) and increment xfer_count.
REQ-021 While ready=0, all outputs SHALL hold stable.
REQ-022 When the last set bit completes, the next state SHALL be DONE; DONE SHALL assert done for exactly one cycle (valid=0, busy=1) and then return to IDLE.
REQ-023 The first transfer SHALL be presented one cycle after start is accepted, and mem_addr of the first transfer SHALL equal base_addr.
REQ-024 start SHALL be ignored in RUN and DONE; start in the same cycle that DONE returns to IDLE SHALL NOT be accepted.
REQ-025 In every state other than RUN, valid and reg_we SHALL be 0.

Reset
REQ-026 Asserting reset (low) at any time, including mid-sequence, SHALL force IDLE immediately.
REQ-027 Under reset, reg_addr, mem_addr, xfer_count, valid, load_o, busy and done SHALL all be 0, and the remaining mask SHALL be cleared.
REQ-028 After reset is released, no transfer SHALL occur until a new start is accepted.

Configuration
REQ-029 With LMSM_R7_SKIP_EN defined, mask bit 7 SHALL be masked off at capture, so R7 (the PC) is never transferred, and a mask of 8'h80 SHALL go directly to DONE.
REQ-030 Without LMSM_R7_SKIP_EN, bit 7 SHALL be treated like any other bit, so reg_addr=7 can be emitted.

Structure
REQ-031 A shared package lmsm_pkg SHALL hold the state enum (IDLE/RUN/DONE), REG_AW=3, DATA_W=16 and MASK_W=8.
REQ-032 Lowest-set-bit selection SHALL be a sub-module named prio_enc8: combinational, taking the 8-bit mask and producing a 3-bit index plus an any flag.

Verification
REQ-033 Scenario: start, is_load=0, mask=8'b0010_0101, base=16'h0040, ready=1 -> reg_addr 0,2,5 with mem_addr 0040,0041,0042 on consecutive cycles, then done one cycle later, xfer_count=3.
REQ-034 Scenario: LM with mask=8'hFF, base=16'hFFFE -> mem_addr wraps FFFE,FFFF,0000,...; reg_we pulses per transfer (7 transfers with LMSM_R7_SKIP_EN, 8 without).
REQ-035 Scenario: mask=8'h00 -> no valid cycles; done asserted the cycle after start.
REQ-036 Scenario: mask=8'h03 with ready held low for 3 cycles on the first transfer -> reg_addr=0 and mem_addr held for the stall, then R1 is transferred and the sequence completes.
REQ-037 Scenario: reset pulsed low during RUN after 2 of 4 transfers -> all outputs 0 immediately and IDLE; a later start with a new mask runs correctly from xfer_count=0.
REQ-038 Scenario: start held high throughout a sequence -> a second sequence begins only after IDLE is reached (no accept in DONE).

Source files
------------

// File: rtl/lmsm_pkg.sv
// Shared types and widths for the LM/SM multi-register transfer sequencer.
package lmsm_pkg;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lmsm_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in i_mask, plus an any-bit-set flag.
module prio_enc8
  import lmsm_pkg::*;
(
  input  logic [MASK_W-1:0] i_mask,
  output logic [REG_AW-1:0] o_idx,
  output logic              o_any
);

  always_comb begin
    o_idx = '0;
    // Scan downwards so the lowest set bit is the last assignment and wins.
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = REG_AW'(i);
    end
    o_any = |i_mask;
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask in ascending order, one transfer per accepted beat.
// Build option LMSM_R7_SKIP_EN drops mask bit 7 (the PC) at capture.
module lm_sm_sequencer
  import lmsm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [MASK_W-1:0] mask,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              ready,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] mem_addr,
  output logic              valid,
  output logic              load_o,
  output logic              reg_we,
  output logic              busy,
  output logic              done,
  output logic [3:0]        xfer_count
);

  lmsm_state_e       r_state, w_state_d;
  logic [MASK_W-1:0] r_mask;
  logic [DATA_W-1:0] r_mem_addr;
  logic              r_load;
  logic [3:0]        r_count;

  logic [MASK_W-1:0] w_cap_mask;
  logic [MASK_W-1:0] w_mask_next;
  logic [REG_AW-1:0] w_idx;
  logic              w_any;
  logic              w_fire;

`ifdef LMSM_R7_SKIP_EN
  assign w_cap_mask = mask & 8'h7F;
`else
  assign w_cap_mask = mask;
`endif

  prio_enc8 u_prio_enc8 (
    .i_mask (r_mask),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign valid       = (r_state == RUN) && w_any;
  assign w_fire      = valid && ready;
  // Clearing the lowest set bit matches the encoder's pick.
  assign w_mask_next = r_mask & (r_mask - 8'd1);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_d = (|w_cap_mask) ? RUN : DONE;
      RUN:     if (w_fire && (w_mask_next == '0)) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_mem_addr <= '0;
      r_load     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == IDLE) && start) begin
        r_mask     <= w_cap_mask;
        r_mem_addr <= base_addr;
        r_load     <= is_load;
        r_count    <= '0;
      end else if (w_fire) begin
        r_mask     <= w_mask_next;
        r_mem_addr <= r_mem_addr + 16'd1;
        r_count    <= r_count + 4'd1;
      end
    end
  end

  assign reg_addr   = w_idx;
  assign mem_addr   = r_mem_addr;
  assign load_o     = r_load;
  assign reg_we     = w_fire && r_load;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign xfer_count = r_count;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer with hand-computed expectations.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_load;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic        ready;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;
  logic        valid;
  logic        load_o;
  logic        reg_we;
  logic        busy;
  logic        done;
  logic [3:0]  xfer_count;

  int n_checks = 0;
  int n_errors = 0;

  lm_sm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .mask       (mask),
    .base_addr  (base_addr),
    .ready      (ready),
    .reg_addr   (reg_addr),
    .mem_addr   (mem_addr),
    .valid      (valid),
    .load_o     (load_o),
    .reg_we     (reg_we),
    .busy       (busy),
    .done       (done),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then drop it.
  task automatic launch(input logic ld, input logic [7:0] m, input logic [15:0] b);
    start     = 1'b1;
    is_load   = ld;
    mask      = m;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic check_xfer(input string tag, input logic [2:0] ra, input logic [15:0] ma,
                            input logic [3:0] cnt);
    check({tag, " valid"}, 16'(valid), 16'd1);
    check({tag, " reg_addr"}, 16'(reg_addr), 16'(ra));
    check({tag, " mem_addr"}, mem_addr, ma);
    check({tag, " xfer_count"}, 16'(xfer_count), 16'(cnt));
  endtask

  initial begin
    int n_exp;
    reset = 1'b0; start = 1'b0; is_load = 1'b0; mask = '0; base_addr = '0; ready = 1'b1;
    #12;
    check("rst valid", 16'(valid), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst done", 16'(done), 16'd0);
    check("rst mem_addr", mem_addr, 16'h0000);
    check("rst count", 16'(xfer_count), 16'd0);
    check("rst reg_addr", 16'(reg_addr), 16'd0);
    reset = 1'b1;
    tick();

    // SM, mask 0010_0101, base 0040
    launch(1'b0, 8'b0010_0101, 16'h0040);
    check_xfer("s1 x0", 3'd0, 16'h0040, 4'd0);
    check("s1 busy", 16'(busy), 16'd1);
    check("s1 reg_we", 16'(reg_we), 16'd0);
    tick();
    check_xfer("s1 x1", 3'd2, 16'h0041, 4'd1);
    tick();
    check_xfer("s1 x2", 3'd5, 16'h0042, 4'd2);
    tick();
    check("s1 done", 16'(done), 16'd1);
    check("s1 done valid", 16'(valid), 16'd0);
    check("s1 done busy", 16'(busy), 16'd1);
    check("s1 count", 16'(xfer_count), 16'd3);
    tick();
    check("s1 idle done", 16'(done), 16'd0);
    check("s1 idle busy", 16'(busy), 16'd0);

    // LM, mask FF, base FFFE: address wrap
`ifdef LMSM_R7_SKIP_EN
    n_exp = 7;
`else
    n_exp = 8;
`endif
    launch(1'b1, 8'hFF, 16'hFFFE);
    check("s2 load_o", 16'(load_o), 16'd1);
    for (int i = 0; i < n_exp; i++) begin
      check_xfer($sformatf("s2 x%0d", i), 3'(i), 16'hFFFE + 16'(i), 4'(i));
      check($sformatf("s2 x%0d reg_we", i), 16'(reg_we), 16'd1);
      tick();
    end
    check("s2 done", 16'(done), 16'd1);
    check("s2 reg_we", 16'(reg_we), 16'd0);
    check("s2 count", 16'(xfer_count), 16'(n_exp));
    tick();

    // Empty mask goes straight to DONE
    launch(1'b0, 8'h00, 16'h1234);
    check("s3 done", 16'(done), 16'd1);
    check("s3 valid", 16'(valid), 16'd0);
    check("s3 busy", 16'(busy), 16'd1);
    tick();
    check("s3 idle", 16'(busy), 16'd0);

    // Stall: mask 03, ready low for 3 cycles
    ready = 1'b0;
    launch(1'b1, 8'h03, 16'h0500);
    for (int i = 0; i < 3; i++) begin
      check_xfer($sformatf("s4 stall%0d", i), 3'd0, 16'h0500, 4'd0);
      check($sformatf("s4 stall%0d reg_we", i), 16'(reg_we), 16'd0);
      tick();
    end
    ready = 1'b1;
    #1;
    check("s4 reg_we", 16'(reg_we), 16'd1);
    tick();
    check_xfer("s4 x1", 3'd1, 16'h0501, 4'd1);
    tick();
    check("s4 done", 16'(done), 16'd1);
    check("s4 count", 16'(xfer_count), 16'd2);
    tick();

    // Reset mid-sequence after 2 of 4 transfers
    launch(1'b0, 8'h0F, 16'h0100);
    tick();
    tick();
    check_xfer("s5 pre", 3'd2, 16'h0102, 4'd2);
    reset = 1'b0;
    #1;
    check("s5 rst valid", 16'(valid), 16'd0);
    check("s5 rst busy", 16'(busy), 16'd0);
    check("s5 rst mem", mem_addr, 16'h0000);
    check("s5 rst count", 16'(xfer_count), 16'd0);
    check("s5 rst reg_addr", 16'(reg_addr), 16'd0);
    check("s5 rst load_o", 16'(load_o), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    check("s5 no xfer", 16'(valid), 16'd0);
    launch(1'b0, 8'h0A, 16'h0200);
    check_xfer("s5 n0", 3'd1, 16'h0200, 4'd0);
    tick();
    check_xfer("s5 n1", 3'd3, 16'h0201, 4'd1);
    tick();
    check("s5 done", 16'(done), 16'd1);
    check("s5 count", 16'(xfer_count), 16'd2);
    tick();

    // R7 handling
    launch(1'b0, 8'h80, 16'h0700);
`ifdef LMSM_R7_SKIP_EN
    check("s6 r7 skip done", 16'(done), 16'd1);
    check("s6 r7 skip valid", 16'(valid), 16'd0);
    tick();
`else
    check_xfer("s6 r7", 3'd7, 16'h0700, 4'd0);
    tick();
    check("s6 r7 done", 16'(done), 16'd1);
    tick();
`endif

    // start held high: no accept in DONE
    start = 1'b1; is_load = 1'b0; mask = 8'h01; base_addr = 16'h0300;
    tick();
    check_xfer("s7 x0", 3'd0, 16'h0300, 4'd0);
    tick();
    check("s7 done", 16'(done), 16'd1);
    tick();
    check("s7 idle busy", 16'(busy), 16'd0);
    check("s7 idle valid", 16'(valid), 16'd0);
    tick();
    check_xfer("s7 again", 3'd0, 16'h0300, 4'd0);
    start = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
